// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM slave.
// hready is the bus-level ready returned by the interconnect.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 12
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic [31:0]       hrdata;
  logic              hreadyout;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a word-organised register file: registered address
// phase, programmable wait states, two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic             clk,
  input logic             reset,
  ahb_sram_slave_if.slave bus
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT   = (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [3:0]      WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_valid;
  logic             r_write;
  logic [2:0]       r_size;
  logic [IDX_W+1:0] r_addr;
  logic [31:0]      r_mem [DEPTH];

  logic             w_active;
  logic             w_accept;
  logic             w_err;
  logic             w_commit;
  logic [3:0]       w_be;
  logic [IDX_W-1:0] w_idx;

  // Only states that drive hreadyout high can close an address phase.
  assign w_active = (bus.htrans == 2'b10) || (bus.htrans == 2'b11);
  assign w_accept = (r_state inside {S_IDLE, S_DATA, S_ERR2}) &&
                    bus.hsel && bus.hready && w_active;
  assign w_err    = ({1'b0, bus.haddr} >= LIMIT) ||
                    (bus.hsize > 3'd2) ||
                    ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                    ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_commit = (r_state == S_DATA) && r_valid && r_write;

  always_comb begin
    w_state_nxt   = S_IDLE;
    w_cnt_nxt     = r_cnt;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
    case (r_state)
      S_WAIT: begin
        bus.hreadyout = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_DATA: begin
        bus.hrdata = r_mem[w_idx];
      end
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        w_state_nxt   = S_ERR2;
      end
      S_ERR2: begin
        bus.hresp = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_accept) begin
      if (w_err) begin
        w_state_nxt = S_ERR1;
      end else if (WAIT_STATES == 0) begin
        w_state_nxt = S_DATA;
      end else begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = WS_LOAD;
      end
    end
  end

  always_comb begin
    w_be = '0;
    case (r_size)
      3'd0:    w_be[r_addr[1:0]] = 1'b1;
      3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_write <= bus.hwrite;
        r_size  <= bus.hsize;
        r_addr  <= bus.haddr[IDX_W+1:0];
      end else if (w_state_nxt == S_IDLE) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Memory has no reset; reset still blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: zero-wait and three-wait instances driven by a
// pipelined table master, with a scoreboard checking each data phase.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_hsel;
  logic [11:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        hready_force;
  int          sel;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.ADDR_W(12)) if0 ();
  ahb_sram_slave_if #(.ADDR_W(12)) if3 ();

  assign if0.hsel   = m_hsel && (sel == 0);
  assign if0.haddr  = m_haddr;
  assign if0.htrans = m_htrans;
  assign if0.hwrite = m_hwrite;
  assign if0.hsize  = m_hsize;
  assign if0.hwdata = m_hwdata;
  assign if0.hready = if0.hreadyout && !hready_force;

  assign if3.hsel   = m_hsel && (sel == 1);
  assign if3.haddr  = m_haddr;
  assign if3.htrans = m_htrans;
  assign if3.hwrite = m_hwrite;
  assign if3.hsize  = m_hsize;
  assign if3.hwdata = m_hwdata;
  assign if3.hready = if3.hreadyout && !hready_force;

  ahb_sram_slave #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  ahb_sram_slave #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  logic        s_hsel, s_hready, s_hreadyout, s_hresp;
  logic [31:0] s_hrdata;
  int          ws_sel;
  assign s_hsel      = (sel == 0) ? if0.hsel      : if3.hsel;
  assign s_hready    = (sel == 0) ? if0.hready    : if3.hready;
  assign s_hreadyout = (sel == 0) ? if0.hreadyout : if3.hreadyout;
  assign s_hresp     = (sel == 0) ? if0.hresp     : if3.hresp;
  assign s_hrdata    = (sel == 0) ? if0.hrdata    : if3.hrdata;
  assign ws_sel      = (sel == 0) ? 0 : 3;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  vec_t vec[$];
  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   inflight = 0;
  bit   mon_en = 0;
  int   low_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [11:0] a, input logic [31:0] wd,
                     input logic er, input logic [31:0] rd);
    vec_t v;
    v.trans = tr; v.wr = wr; v.size = sz; v.addr = a;
    v.wdata = wd; v.err = er; v.rdata = rd;
    vec.push_back(v);
  endtask

  // Data-phase monitor: counts wait cycles and checks the completing cycle.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      inflight = 0;
    end else begin
      if (inflight) begin
        if (!s_hreadyout) begin
          low_cnt++;
          check32("hresp_low", {31'b0, s_hresp}, {31'b0, cur.err});
          check32("hrdata_low", s_hrdata, 32'h0);
        end else begin
          check32("low_cycles", 32'(low_cnt), cur.err ? 32'd1 : 32'(ws_sel));
          check32("hresp_done", {31'b0, s_hresp}, {31'b0, cur.err});
          if (cur.err) check32("hrdata_err", s_hrdata, 32'h0);
          else if (cur.rd) check32("hrdata", s_hrdata, cur.rdata);
          inflight = 0;
        end
      end
      if (s_hsel && s_hready && m_htrans[1]) begin
        if (sb.size() == 0) begin
          fail_now("sb_underflow");
        end else begin
          cur      = sb.pop_front();
          inflight = 1;
          low_cnt  = 0;
        end
      end
    end
  end

  task automatic drive_idle();
    m_hsel   = 1'b0;
    m_htrans = 2'b00;
    m_hwrite = 1'b0;
    m_hsize  = 3'd0;
    m_haddr  = '0;
  endtask

  task automatic present(input int k);
    exp_t e;
    m_hsel   = 1'b1;
    m_haddr  = vec[k].addr;
    m_htrans = vec[k].trans;
    m_hwrite = vec[k].wr;
    m_hsize  = vec[k].size;
    e.rd     = !vec[k].wr;
    e.err    = vec[k].err;
    e.rdata  = vec[k].rdata;
    sb.push_back(e);
  endtask

  // Back-to-back pipelined issue of vec[first..last-1]; entered at posedge+1.
  task automatic run_table(input int first, input int last);
    int  i = first;
    int  guard = 0;
    bit  acc;
    present(i);
    while (i < last && guard < 300) begin
      @(negedge clk);
      acc = s_hsel && s_hready && m_htrans[1];
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        m_hwdata = vec[i].wdata;
        i++;
        if (i < last) present(i);
        else drive_idle();
      end
    end
    if (i < last) fail_now("issue_timeout");
    for (int g = 0; g < 30; g++) begin
      if (!inflight) break;
      @(posedge clk);
      #1;
    end
    if (inflight) fail_now("drain_timeout");
  endtask

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  initial begin
    int a0, a1, b0, b1, c0, c1, d0, d1;
    logic [1:0] g_trans [4];
    logic       g_sel   [4];
    logic       g_force [4];

    reset = 1'b1; sel = 0; hready_force = 1'b0; m_hwdata = '0;
    drive_idle();

    // Zero-wait functional vectors
    a0 = vec.size();
    add(NS, 1, 3'd2, 12'h010, 32'hDEADBEEF, 0, 32'h0);
    add(NS, 0, 3'd2, 12'h010, 32'h0,        0, 32'hDEADBEEF);
    add(NS, 1, 3'd2, 12'h020, 32'h11223344, 0, 32'h0);
    add(SQ, 1, 3'd0, 12'h022, 32'h00AA0000, 0, 32'h0);
    add(NS, 0, 3'd2, 12'h020, 32'h0,        0, 32'h11AA3344);
    add(NS, 1, 3'd1, 12'h020, 32'h0000BEEF, 0, 32'h0);
    add(SQ, 0, 3'd2, 12'h020, 32'h0,        0, 32'h11AABEEF);
    add(NS, 1, 3'd2, 12'h000, 32'h00C0FFEE, 0, 32'h0);
    add(NS, 1, 3'd2, 12'h400, 32'h12345678, 1, 32'h0);
    add(NS, 0, 3'd2, 12'h012, 32'h0,        1, 32'h0);
    add(NS, 1, 3'd3, 12'h010, 32'hFFFFFFFF, 1, 32'h0);
    add(NS, 1, 3'd1, 12'h023, 32'hFFFFFFFF, 1, 32'h0);
    add(NS, 0, 3'd2, 12'h000, 32'h0,        0, 32'h00C0FFEE);
    add(NS, 0, 3'd2, 12'h010, 32'h0,        0, 32'hDEADBEEF);
    add(NS, 0, 3'd2, 12'h020, 32'h0,        0, 32'h11AABEEF);
    add(NS, 1, 3'd0, 12'h023, 32'h55000000, 0, 32'h0);
    add(NS, 1, 3'd2, 12'h3FC, 32'hCAFEF00D, 0, 32'h0);
    add(NS, 1, 3'd2, 12'h024, 32'hA5A5A5A5, 0, 32'h0);
    add(NS, 1, 3'd1, 12'h026, 32'h12340000, 0, 32'h0);
    add(NS, 0, 3'd2, 12'h020, 32'h0,        0, 32'h55AABEEF);
    add(NS, 0, 3'd2, 12'h3FC, 32'h0,        0, 32'hCAFEF00D);
    add(NS, 0, 3'd0, 12'h025, 32'h0,        0, 32'h1234A5A5);
    add(NS, 1, 3'd2, 12'hFFC, 32'h0BAD0BAD, 1, 32'h0);
    add(NS, 0, 3'd1, 12'h3FE, 32'h0,        0, 32'hCAFEF00D);
    a1 = vec.size();
    d0 = vec.size();
    add(NS, 0, 3'd2, 12'h010, 32'h0,        0, 32'hDEADBEEF);
    d1 = vec.size();
    // Three-wait instance vectors
    b0 = vec.size();
    add(NS, 1, 3'd2, 12'h040, 32'h0BADF00D, 0, 32'h0);
    add(NS, 1, 3'd2, 12'h044, 32'h600DCAFE, 0, 32'h0);
    add(NS, 0, 3'd2, 12'h040, 32'h0,        0, 32'h0BADF00D);
    add(NS, 0, 3'd2, 12'h044, 32'h0,        0, 32'h600DCAFE);
    add(NS, 1, 3'd2, 12'h030, 32'h11111111, 0, 32'h0);
    add(NS, 0, 3'd0, 12'h401, 32'h0,        1, 32'h0);
    b1 = vec.size();
    c0 = vec.size();
    add(NS, 0, 3'd2, 12'h030, 32'h0,        0, 32'h11111111);
    c1 = vec.size();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_rdy0",  {31'b0, if0.hreadyout}, 32'd1);
    check32("rst_resp0", {31'b0, if0.hresp},     32'd0);
    check32("rst_data0", if0.hrdata,             32'h0);
    check32("rst_rdy3",  {31'b0, if3.hreadyout}, 32'd1);
    check32("rst_resp3", {31'b0, if3.hresp},     32'd0);
    check32("rst_data3", if3.hrdata,             32'h0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1;

    sel = 0;
    run_table(a0, a1);

    // Gated address phases must never be captured
    g_trans = '{2'b00, 2'b01, 2'b10, 2'b10};
    g_sel   = '{1'b1,  1'b1,  1'b0,  1'b1};
    g_force = '{1'b0,  1'b0,  1'b0,  1'b1};
    m_hwdata = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      m_hsel = g_sel[k]; m_htrans = g_trans[k]; m_hwrite = 1'b1;
      m_hsize = 3'd2; m_haddr = 12'h010; hready_force = g_force[k];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check32("gate_rdy",   {31'b0, if0.hreadyout}, 32'd1);
        check32("gate_resp",  {31'b0, if0.hresp},     32'd0);
        check32("gate_rdata", if0.hrdata,             32'h0);
        @(posedge clk); #1;
      end
    end
    hready_force = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    run_table(d0, d1);

    sel = 1;
    run_table(b0, b1);

    // Reset while a write to 0x030 sits in WAIT
    mon_en = 0;
    m_hsel = 1'b1; m_haddr = 12'h030; m_htrans = NS; m_hwrite = 1'b1; m_hsize = 3'd2;
    @(posedge clk); #1;
    drive_idle();
    m_hwdata = 32'h22222222;
    @(negedge clk);
    check32("rst_mid_wait", {31'b0, if3.hreadyout}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check32("rst_mid_rdy",   {31'b0, if3.hreadyout}, 32'd1);
    check32("rst_mid_resp",  {31'b0, if3.hresp},     32'd0);
    check32("rst_mid_rdata", if3.hrdata,             32'h0);
    repeat (5) @(posedge clk);
    #1;
    mon_en = 1;
    run_table(c0, c1);

    check32("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave backed by a word-organised register-file memory.
- Captures the address-phase controls (address, direction, size, transfer type) into a one-cycle pipeline register. It then runs the data phase with a programmable wait-state count and a two-cycle ERROR response.
- It is the downstream consumer of the bus's registered address-phase signals and the terminal stage of the bus's data path.

Parameters:
- ADDR_W, 12, width of haddr in bits (byte address).
- DEPTH, 256, number of 32-bit words. Legal byte range is 0 to 4*DEPTH-1.
- WAIT_STATES, 0, extra data-phase cycles with hreadyout low before an OKAY completion. Range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- hsel  input  1  slave select.
- haddr  input  ADDR_W  byte address, address phase.
- htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  0 byte, 1 halfword, 2 word; values above 2 are illegal.
- hwdata  input  32  write data, data phase.
- hready  input  1  bus-level ready (previous transfer complete).
- hrdata  output  32  read data.
- hreadyout  output  1  slave ready.
- hresp  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (sampled on clk edge) has priority over everything:
  - FSM goes to IDLE; hreadyout=1, hresp=0, hrdata=0; capture register is invalid.
  - Memory contents are not reset.
  - A transfer in flight is abandoned; a pending write is not committed.
- Accept condition: hsel && hready && htrans[1] on a clk edge. On accept, capture haddr, hwrite, hsize and a valid flag.
- No accept on IDLE or BUSY, when hsel is low, or when hready is low. The slave stays or returns to IDLE with a zero-wait OKAY (hreadyout=1, hresp=0).
- An accepted transfer is an error if any of these hold; otherwise it is legal:
  - haddr >= 4*DEPTH;
  - hsize > 2;
  - hsize==1 and haddr[0]==1;
  - hsize==2 and haddr[1:0]!=0.
- FSM states and transitions:
  - IDLE: hreadyout=1, hresp=0.
    - Legal accept with WAIT_STATES==0 -> DATA.
    - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Error accept -> ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> DATA. Input hready is low during WAIT, so no new accept occurs.
  - DATA: hreadyout=1, hresp=0; final data-phase cycle.
    - Write commits at the clk edge ending DATA.
    - Pipelined accept in the same cycle takes the same transitions as from IDLE; with no accept -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2. Nothing is written.
  - ERR2: hreadyout=1, hresp=1. A pipelined accept is honoured (next transfer proceeds normally); with no accept -> IDLE.
- Latency: total data-phase length is 1+WAIT_STATES cycles for OKAY and exactly 2 cycles for ERROR.
- Write byte lanes (little-endian) at word index haddr[ADDR_W-1:2]:
  - byte: lane haddr[1:0], bits 8*lane+7:8*lane;
  - halfword: lanes 2*haddr[1] and 2*haddr[1]+1;
  - word: all four lanes.
  - Unselected lanes are unchanged.
- hwdata is sampled only in DATA.
- Reads:
  - In DATA, hrdata = full memory word at the captured index; the master extracts its lanes.
  - hrdata = 0 in every other state, including error states.
- Read-after-write: a read whose address phase coincides with the DATA cycle of a write to the same word returns the newly written data. The write commits at that edge and the read is presented in the following cycle.
- A BUSY inside a burst is treated as IDLE (zero-wait OKAY, no capture).
- A SEQ transfer is accepted like NONSEQ; no burst address checking is done.

Test Plan:
- Word write/read, WAIT_STATES=0: NONSEQ write 0x010 data 0xDEADBEEF, then NONSEQ read 0x010 -> hrdata=0xDEADBEEF, hresp=0, hreadyout never low.
- Byte lanes: word write 0x11223344 to 0x020, then byte write 0xAA to 0x022 (hwdata 0x00AA0000), then read 0x020 -> 0x11AA3344. A halfword write 0xBEEF to 0x020 (hwdata 0x0000BEEF) then reads back 0x11AABEEF.
- Wait states, WAIT_STATES=3: read -> hreadyout low for exactly 3 cycles, then high one cycle with data. A back-to-back pipelined read accepted on that cycle shows the same 3+1 pattern.
- Errors: write to 0x400 (DEPTH=256) -> hreadyout/hresp = 0/1 then 1/1. A misaligned word read at 0x012 and hsize=3 each produce the same two-cycle pattern, and memory is unchanged.
- Gating: htrans=IDLE, hsel=0, or hready=0 with a valid address -> no capture, no write, hreadyout=1, hresp=0 throughout.
- Reset mid-transfer, WAIT_STATES=3: assert reset during WAIT of a write to 0x030 -> next cycle hreadyout=1, hresp=0, hrdata=0. A subsequent read of 0x030 returns the prior contents.
